// File: rtl/nios_system_input_pio_edge_if.sv
// nios_system_input_pio_edge_if: Avalon-MM slave bus bundle for the edge-capturing input PIO
interface nios_system_input_pio_edge_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master(output address, chipselect, write_n, writedata, input readdata);
  modport slave(input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_system_input_pio_edge.sv
// nios_system_input_pio_edge: synchronised input PIO with sticky edge capture, irq mask and level irq
module nios_system_input_pio_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  nios_system_input_pio_edge_if.slave  bus,
  input  logic [WIDTH-1:0]             in_port,
  output logic                         irq
);
  localparam int PW = $clog2(SYNC_STAGES + 2);
  localparam logic [PW-1:0] PRIMED = PW'(SYNC_STAGES + 1);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_prev, r_cap, r_mask;
  logic [PW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_sync, w_rise, w_fall, w_det, w_clr;
  logic             w_wr;
  logic [31:0]      w_rd;
  always_comb begin
    w_sync = r_sync[SYNC_STAGES-1];
    w_rise = w_sync & ~r_prev;
    w_fall = ~w_sync & r_prev;
    // no detection until the chain and prev hold real post-reset samples
    w_det  = (r_cnt != PRIMED) ? '0 :
             (EDGE_TYPE == 0)  ? w_rise :
             (EDGE_TYPE == 1)  ? w_fall : (w_rise | w_fall);
    w_wr   = bus.chipselect & ~bus.write_n;
    w_clr  = (w_wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
    w_rd   = (bus.address == 2'd0) ? 32'(w_sync) :
             (bus.address == 2'd2) ? 32'(r_mask) :
             (bus.address == 2'd3) ? 32'(r_cap)  : '0;
  end
  assign irq = |(r_cap & r_mask);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync       <= '0;
      r_prev       <= '0;
      r_cap        <= '0;
      r_mask       <= '0;
      r_cnt        <= '0;
      bus.readdata <= '0;
    end else begin
      r_sync       <= {r_sync[SYNC_STAGES-2:0], in_port};
      r_prev       <= w_sync;
      r_cap        <= (r_cap & ~w_clr) | w_det;
      r_mask       <= (w_wr && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : r_mask;
      r_cnt        <= (r_cnt == PRIMED) ? r_cnt : r_cnt + PW'(1);
      bus.readdata <= w_rd;
    end
  end
endmodule

// File: tb/tb_nios_system_input_pio_edge.sv
// tb_nios_system_input_pio_edge: directed vector table, edge-type corner sequence and randomized model check
module tb_nios_system_input_pio_edge;
  localparam int SS = 2;
  typedef struct {
    logic        rst;
    logic [7:0]  inp;
    logic        cs;
    logic        wn;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  inp = 8'h00;
  logic        cs = 1'b0;
  logic        wn = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wd = '0;
  logic        irq0, irq1, irq2;
  int          n_chk = 0;
  int          n_fail = 0;
  vec_t        tv[$];
  nios_system_input_pio_edge_if b0();
  nios_system_input_pio_edge_if b1();
  nios_system_input_pio_edge_if b2();
  assign {b0.address, b0.chipselect, b0.write_n, b0.writedata} = {addr, cs, wn, wd};
  assign {b1.address, b1.chipselect, b1.write_n, b1.writedata} = {addr, cs, wn, wd};
  assign {b2.address, b2.chipselect, b2.write_n, b2.writedata} = {addr, cs, wn, wd};
  nios_system_input_pio_edge #(.WIDTH(8), .SYNC_STAGES(SS), .EDGE_TYPE(0)) u0 (
    .clk(clk), .reset(rst), .bus(b0.slave), .in_port(inp), .irq(irq0));
  nios_system_input_pio_edge #(.WIDTH(8), .SYNC_STAGES(SS), .EDGE_TYPE(1)) u1 (
    .clk(clk), .reset(rst), .bus(b1.slave), .in_port(inp), .irq(irq1));
  nios_system_input_pio_edge #(.WIDTH(8), .SYNC_STAGES(SS), .EDGE_TYPE(2)) u2 (
    .clk(clk), .reset(rst), .bus(b2.slave), .in_port(inp), .irq(irq2));
  always #5 clk = ~clk;

  // reference: sync is simply the input sampled SS edges ago, edges need SS+1 post-reset samples
  int          m_n = 0;
  logic [7:0]  m_hist[$];
  logic [7:0]  m_cap[3];
  logic [7:0]  m_mask = '0;
  logic [31:0] m_rd[3];
  always @(posedge clk) begin
    logic [7:0] s, p, clr, det;
    if (rst) begin
      m_n = 0;
      m_hist.delete();
      m_mask = '0;
      for (int k = 0; k < 3; k++) begin
        m_cap[k] = '0;
        m_rd[k] = '0;
      end
    end else begin
      s = (m_n >= SS) ? m_hist[m_n-SS] : 8'h00;
      p = (m_n >= SS + 1) ? m_hist[m_n-SS-1] : 8'h00;
      clr = (cs && !wn && addr == 2'd3) ? wd[7:0] : 8'h00;
      for (int k = 0; k < 3; k++) begin
        m_rd[k] = (addr == 2'd0) ? {24'h0, s} : (addr == 2'd2) ? {24'h0, m_mask} :
                  (addr == 2'd3) ? {24'h0, m_cap[k]} : 32'h0;
        det = (k == 0) ? (s & ~p) : (k == 1) ? (~s & p) : (s ^ p);
        if (m_n < SS + 1) det = 8'h00;
        m_cap[k] = (m_cap[k] & ~clr) | det;
      end
      if (cs && !wn && addr == 2'd2) m_mask = wd[7:0];
      m_hist.push_back(inp);
      m_n++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic r, logic [7:0] i, logic c, logic w, logic [1:0] a,
                              logic [31:0] d, logic [31:0] rd, logic q);
    vec_t v;
    v.rst = r; v.inp = i; v.cs = c; v.wn = w; v.a = a; v.wd = d; v.rd = rd; v.irq = q;
    return v;
  endfunction

  task automatic drive(input logic r, input logic [7:0] i, input logic c, input logic w,
                       input logic [1:0] a, input logic [31:0] d);
    rst = r; inp = i; cs = c; wn = w; addr = a; wd = d;
    @(negedge clk);
  endtask

  initial begin
    // reset with inputs high, priming
    tv.push_back(mk(1, 8'hFF, 0, 1, 0, 0, 32'h0, 0));
    tv.push_back(mk(0, 8'hFF, 0, 1, 0, 0, 32'h0, 0));
    tv.push_back(mk(0, 8'hFF, 0, 1, 0, 0, 32'h0, 0));
    tv.push_back(mk(0, 8'hFF, 0, 1, 0, 0, 32'hFF, 0));
    tv.push_back(mk(0, 8'hFF, 0, 1, 0, 0, 32'hFF, 0));
    tv.push_back(mk(0, 8'hFF, 0, 1, 3, 0, 32'h0, 0));
    // falls ignored, then rise 00->05
    tv.push_back(mk(0, 8'h00, 0, 1, 0, 0, 32'hFF, 0));
    tv.push_back(mk(0, 8'h00, 0, 1, 0, 0, 32'hFF, 0));
    tv.push_back(mk(0, 8'h00, 0, 1, 0, 0, 32'h00, 0));
    tv.push_back(mk(0, 8'h05, 0, 1, 0, 0, 32'h00, 0));
    tv.push_back(mk(0, 8'h05, 0, 1, 0, 0, 32'h00, 0));
    tv.push_back(mk(0, 8'h05, 0, 1, 3, 0, 32'h00, 0));
    tv.push_back(mk(0, 8'h05, 0, 1, 3, 0, 32'h05, 0));
    // mask writes
    tv.push_back(mk(0, 8'h05, 1, 0, 2, 32'h04, 32'h00, 1));
    tv.push_back(mk(0, 8'h05, 0, 1, 2, 0, 32'h04, 1));
    tv.push_back(mk(0, 8'h05, 1, 0, 2, 32'h08, 32'h04, 0));
    tv.push_back(mk(0, 8'h05, 1, 0, 2, 32'h04, 32'h08, 1));
    // write-1-to-clear, pre-clear read value
    tv.push_back(mk(0, 8'h05, 1, 0, 3, 32'h01, 32'h05, 1));
    tv.push_back(mk(0, 8'h05, 0, 1, 3, 0, 32'h04, 1));
    tv.push_back(mk(0, 8'h05, 1, 0, 3, 32'h04, 32'h04, 0));
    tv.push_back(mk(0, 8'h05, 0, 1, 3, 0, 32'h00, 0));
    // reserved / read-only writes, upper mask bits ignored
    tv.push_back(mk(0, 8'h05, 1, 0, 1, 32'hFFFFFFFF, 32'h00, 0));
    tv.push_back(mk(0, 8'h05, 0, 1, 1, 0, 32'h00, 0));
    tv.push_back(mk(0, 8'h05, 1, 0, 0, 32'h00, 32'h05, 0));
    tv.push_back(mk(0, 8'h05, 0, 1, 0, 0, 32'h05, 0));
    tv.push_back(mk(0, 8'h05, 1, 0, 2, 32'hFFFFFF01, 32'h04, 0));
    tv.push_back(mk(0, 8'h05, 0, 1, 2, 0, 32'h01, 0));
    // rise on bit 0 collides with a clear of bit 0: set wins
    tv.push_back(mk(0, 8'h04, 0, 1, 0, 0, 32'h05, 0));
    tv.push_back(mk(0, 8'h04, 0, 1, 0, 0, 32'h05, 0));
    tv.push_back(mk(0, 8'h04, 0, 1, 0, 0, 32'h04, 0));
    tv.push_back(mk(0, 8'h05, 0, 1, 0, 0, 32'h04, 0));
    tv.push_back(mk(0, 8'h05, 0, 1, 0, 0, 32'h04, 0));
    tv.push_back(mk(0, 8'h05, 1, 0, 3, 32'h01, 32'h00, 1));
    tv.push_back(mk(0, 8'h05, 0, 1, 3, 0, 32'h01, 1));
    // mid-operation reset with held-high inputs
    tv.push_back(mk(0, 8'h05, 1, 0, 2, 32'hFF, 32'h01, 1));
    tv.push_back(mk(1, 8'h05, 0, 1, 3, 0, 32'h00, 0));
    tv.push_back(mk(0, 8'h05, 0, 1, 3, 0, 32'h00, 0));
    tv.push_back(mk(0, 8'h05, 0, 1, 2, 0, 32'h00, 0));
    tv.push_back(mk(0, 8'h05, 0, 1, 0, 0, 32'h05, 0));
    tv.push_back(mk(0, 8'h05, 0, 1, 3, 0, 32'h00, 0));
    tv.push_back(mk(0, 8'h05, 0, 1, 3, 0, 32'h00, 0));
    tv.push_back(mk(0, 8'h05, 0, 1, 3, 0, 32'h00, 0));
    @(negedge clk);
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rst, tv[i].inp, tv[i].cs, tv[i].wn, tv[i].a, tv[i].wd);
      chk($sformatf("vec%0d_rd", i), b0.readdata, tv[i].rd);
      chk($sformatf("vec%0d_irq", i), {31'h0, irq0}, {31'h0, tv[i].irq});
    end
    // one-cycle pulse on bit 3 seen by rising / falling / any edge instances
    drive(0, 8'h05, 1, 0, 2, 32'h08);
    drive(0, 8'h05, 1, 0, 3, 32'hFF);
    drive(0, 8'h05, 0, 1, 3, 0);
    chk("pulse_pre_irq", {29'h0, irq0, irq1, irq2}, 32'h0);
    drive(0, 8'h0D, 0, 1, 3, 0);
    drive(0, 8'h05, 0, 1, 3, 0);
    drive(0, 8'h05, 0, 1, 3, 0);
    chk("pulse_rise_irq", {29'h0, irq0, irq1, irq2}, 32'h5);
    drive(0, 8'h05, 0, 1, 3, 0);
    chk("pulse_fall_irq", {29'h0, irq0, irq1, irq2}, 32'h7);
    chk("pulse_rise_rd_any", b2.readdata, 32'h08);
    chk("pulse_rise_rd_fall", b1.readdata, 32'h00);
    drive(0, 8'h05, 0, 1, 3, 0);
    chk("pulse_cap_rise", b0.readdata, 32'h08);
    chk("pulse_cap_fall", b1.readdata, 32'h08);
    chk("pulse_cap_any", b2.readdata, 32'h08);
    // randomized traffic against the reference
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0) ? 8'($urandom) : inp,
            1'($urandom), 1'($urandom), 2'($urandom), $urandom);
      chk("rnd_rd_rise", b0.readdata, m_rd[0]);
      chk("rnd_rd_fall", b1.readdata, m_rd[1]);
      chk("rnd_rd_any", b2.readdata, m_rd[2]);
      chk("rnd_irq", {29'h0, irq0, irq1, irq2},
          {29'h0, |(m_cap[0] & m_mask), |(m_cap[1] & m_mask), |(m_cap[2] & m_mask)});
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
